// File: rtl/hex8_pkg.sv
// Shared definitions for the hex8 7-segment scanner.
// Contents: the frame word width, default scan and shift timing, the frame step count,
// and the active-low hex-to-segment decode (bit7 = DP, always 1 = off).
package hex8_pkg;

  localparam int unsigned WORD_W       = 16;
  localparam int unsigned SCAN_CNT_DEF = 50_000;
  localparam int unsigned SHCP_DIV_DEF = 2;
  // Steps 0..31 shift 16 bits (data step, then clock-high step); step 32 latches.
  localparam int unsigned LAST_STEP    = 32;

  function automatic logic [7:0] seg_decode(input logic [3:0] nibble);
    logic [7:0] seg;
    case (nibble)
      4'h0: seg = 8'hC0;
      4'h1: seg = 8'hF9;
      4'h2: seg = 8'hA4;
      4'h3: seg = 8'hB0;
      4'h4: seg = 8'h99;
      4'h5: seg = 8'h92;
      4'h6: seg = 8'h82;
      4'h7: seg = 8'hF8;
      4'h8: seg = 8'h80;
      4'h9: seg = 8'h90;
      4'hA: seg = 8'h88;
      4'hB: seg = 8'h83;
      4'hC: seg = 8'hC6;
      4'hD: seg = 8'hA1;
      4'hE: seg = 8'h86;
      default: seg = 8'h8E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/hex8_hc595_shift.sv
// Serialises a 16-bit word into two cascaded 74HC595s, MSB first, then pulses STCP.
// Ports:
//   Clk   - system clock
//   Reset - synchronous active-high reset
//   word  - word to send; sampled once per frame at the step-0 tick
//   DS    - serial data, stable a full half-period either side of each SHCP rise
//   SHCP  - shift clock (595 samples DS on its rising edge)
//   STCP  - storage clock, high for one step at the end of every frame
module hex8_hc595_shift
  import hex8_pkg::*;
#(
  parameter int unsigned SHCP_DIV = SHCP_DIV_DEF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [WORD_W-1:0] word,
  output logic              DS,
  output logic              SHCP,
  output logic              STCP
);

  localparam int unsigned DivW = (SHCP_DIV > 1) ? $clog2(SHCP_DIV) : 1;

  logic [DivW-1:0]   div_q;
  logic [5:0]        step_q;
  logic [WORD_W-1:0] word_q;
  logic              tick;
  logic [3:0]        bit_idx;

  assign tick    = (div_q == DivW'(SHCP_DIV - 1));
  // Even step 2i presents word bit 15-i.
  assign bit_idx = 4'd15 - step_q[4:1];

  // step_q names the step whose output update happens at the next tick, so the
  // first tick after reset latches a fresh word rather than shifting out zeros.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      div_q  <= '0;
      step_q <= '0;
      word_q <= '0;
      DS     <= 1'b0;
      SHCP   <= 1'b0;
      STCP   <= 1'b0;
    end else begin
      div_q <= tick ? '0 : div_q + DivW'(1);
      if (tick) begin
        step_q <= (step_q == 6'(LAST_STEP)) ? 6'd0 : step_q + 6'd1;
        if (step_q == 6'd0) begin
          word_q <= word;
          DS     <= word[WORD_W-1];
          SHCP   <= 1'b0;
          STCP   <= 1'b0;
        end else if (step_q == 6'(LAST_STEP)) begin
          SHCP <= 1'b0;
          STCP <= 1'b1;
        end else if (step_q[0]) begin
          SHCP <= 1'b1;
        end else begin
          DS   <= word_q[bit_idx];
          SHCP <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/hex8_test.sv
// 8-digit common-anode hex display scanner driving two cascaded 74HC595s.
// Each digit stays selected for SCAN_CNT clocks; the {sel, seg} word is resent continuously.
// Ports:
//   Clk       - system clock (50 MHz nominal)
//   Reset     - synchronous active-high reset
//   Disp_data - eight hex nibbles, digit k shows Disp_data[4k+3:4k]
//   DS        - serial data to the 595 chain
//   SHCP      - 595 shift clock
//   STCP      - 595 storage/latch clock
module hex8_test
  import hex8_pkg::*;
#(
  parameter int unsigned SCAN_CNT = SCAN_CNT_DEF,
  parameter int unsigned SHCP_DIV = SHCP_DIV_DEF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] Disp_data,
  output logic        DS,
  output logic        SHCP,
  output logic        STCP
);

  localparam int unsigned ScanW = (SCAN_CNT > 1) ? $clog2(SCAN_CNT) : 1;

  logic [ScanW-1:0]  scan_q;
  logic [2:0]        index_q;
  logic [3:0]        nibble;
  logic [7:0]        sel;
  logic [7:0]        seg;
  logic [WORD_W-1:0] word;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      scan_q  <= '0;
      index_q <= '0;
    end else if (scan_q == ScanW'(SCAN_CNT - 1)) begin
      scan_q  <= '0;
      index_q <= index_q + 3'd1;
    end else begin
      scan_q <= scan_q + ScanW'(1);
    end
  end

  always_comb begin
    sel    = 8'd1 << index_q;
    nibble = Disp_data[{index_q, 2'b00} +: 4];
    seg    = seg_decode(nibble);
    // sel goes out first so it ends up in the far 595.
    word   = {sel, seg};
  end

  hex8_hc595_shift #(
    .SHCP_DIV(SHCP_DIV)
  ) u_shift (
    .Clk  (Clk),
    .Reset(Reset),
    .word (word),
    .DS   (DS),
    .SHCP (SHCP),
    .STCP (STCP)
  );

endmodule

// File: tb/tb_hex8_test.sv
// Bench for hex8_test. SCAN_CNT equals the frame length, so each frame shows the next digit.
module tb_hex8_test;

  localparam int unsigned ScanCnt     = 66;
  localparam int unsigned ShcpDiv     = 2;
  localparam int          FramePeriod = 33 * ShcpDiv;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [31:0] Disp_data = '0;
  logic        DS;
  logic        SHCP;
  logic        STCP;

  hex8_test #(
    .SCAN_CNT(ScanCnt),
    .SHCP_DIV(ShcpDiv)
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Disp_data(Disp_data),
    .DS       (DS),
    .SHCP     (SHCP),
    .STCP     (STCP)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [15:0] word;
    int          rises;
    int          cyc;
  } frame_t;

  typedef struct {
    logic [31:0] data;
    int          frame;
    logic [15:0] exp;
  } vec_t;

  frame_t      fq[$];
  vec_t        vecs[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  logic [15:0] sh = '0;
  int          rises = 0;
  int          hi_w = 0;
  int          last_w = 0;
  int          ds_bad = 0;
  logic        p_shcp = 1'b0;
  logic        p_stcp = 1'b0;
  logic        p_ds = 1'b0;

  // 595-chain model: shift DS on SHCP rise, capture the word on STCP rise.
  initial begin
    forever begin
      @(negedge Clk);
      cyc++;
      if (Reset) begin
        fq.delete();
        sh     = '0;
        rises  = 0;
        hi_w   = 0;
        last_w = 0;
      end else begin
        if (SHCP && !p_shcp) begin
          sh = {sh[14:0], DS};
          rises++;
          if (DS !== p_ds) ds_bad++;
        end
        if (STCP) hi_w++;
        else if (p_stcp) begin
          last_w = hi_w;
          hi_w   = 0;
        end
        if (STCP && !p_stcp) begin
          fq.push_back('{sh, rises, cyc});
          rises = 0;
        end
      end
      p_shcp = SHCP;
      p_stcp = STCP;
      p_ds   = DS;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic get_frame(output frame_t f);
    int n;
    n = 0;
    while (fq.size() == 0 && n < 3 * FramePeriod) begin
      @(negedge Clk);
      #1;
      n++;
    end
    if (fq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL frame_timeout: got no STCP within %0d cycles, expected one", n);
      f = '{16'h0000, -1, -1};
    end else begin
      f = fq.pop_front();
    end
  endtask

  task automatic apply_reset(input logic [31:0] data);
    @(posedge Clk);
    #1;
    Reset     = 1'b1;
    Disp_data = data;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("reset_outputs", {29'd0, DS, SHCP, STCP}, 32'd0);
    @(posedge Clk);
    #1;
    Reset = 1'b0;
  endtask

  task automatic add(input logic [31:0] data, input int frame, input logic [15:0] exp);
    vecs.push_back('{data, frame, exp});
  endtask

  initial begin
    frame_t f;
    int     cur;
    int     prev_cyc;

    add(32'h0000_0000, 0, 16'h01C0);
    add(32'h0000_0000, 1, 16'h02C0);
    add(32'h1234_5678, 0, 16'h0180);
    add(32'h1234_5678, 1, 16'h02F8);
    add(32'h1234_5678, 2, 16'h0482);
    add(32'h1234_5678, 3, 16'h0892);
    add(32'h1234_5678, 4, 16'h1099);
    add(32'h1234_5678, 5, 16'h20B0);
    add(32'h1234_5678, 6, 16'h40A4);
    add(32'h1234_5678, 7, 16'h80F9);
    add(32'h1234_5678, 8, 16'h0180);
    add(32'hFEDC_BA90, 0, 16'h01C0);
    add(32'hFEDC_BA90, 1, 16'h0290);
    add(32'hFEDC_BA90, 2, 16'h0488);
    add(32'hFEDC_BA90, 3, 16'h0883);
    add(32'hFEDC_BA90, 4, 16'h10C6);
    add(32'hFEDC_BA90, 5, 16'h20A1);
    add(32'hFEDC_BA90, 6, 16'h4086);
    add(32'hFEDC_BA90, 7, 16'h808E);

    cur      = -1;
    prev_cyc = 0;
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].frame == 0) begin
        apply_reset(vecs[i].data);
        cur = -1;
      end
      while (cur < vecs[i].frame) begin
        get_frame(f);
        cur++;
        if (cur > 0) begin
          chk("frame_period", f.cyc - prev_cyc, FramePeriod);
          chk("stcp_width", last_w, ShcpDiv);
        end
        prev_cyc = f.cyc;
      end
      chk($sformatf("word_%h_f%0d", vecs[i].data, vecs[i].frame), {16'd0, f.word},
          {16'd0, vecs[i].exp});
      chk($sformatf("shifts_%h_f%0d", vecs[i].data, vecs[i].frame), f.rises, 16);
    end

    // Disp_data changed around step 10: frame in flight keeps the old word.
    apply_reset(32'h0000_0000);
    repeat (21) @(posedge Clk);
    #1;
    Disp_data = 32'hFFFF_FFFF;
    get_frame(f);
    chk("midframe_old", {16'd0, f.word}, 32'h0000_01C0);
    get_frame(f);
    chk("midframe_new", {16'd0, f.word}, 32'h0000_028E);

    // Reset pulsed around step 20 of the second frame.
    apply_reset(32'h1234_5678);
    get_frame(f);
    chk("prereset_word", {16'd0, f.word}, 32'h0000_0180);
    repeat (42) @(posedge Clk);
    #1;
    Reset = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    chk("abort_outputs", {29'd0, DS, SHCP, STCP}, 32'd0);
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    get_frame(f);
    chk("postreset_word", {16'd0, f.word}, 32'h0000_0180);
    chk("postreset_shifts", f.rises, 16);
    get_frame(f);
    chk("postreset_next", {16'd0, f.word}, 32'h0000_02F8);

    chk("ds_stable_at_shcp", ds_bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
